// File: rtl/mux_pkg.sv
// Shared constants and state encoding for the N-to-1 channel serializer.
package mux_pkg;

  localparam int NUM_CH_DEF     = 16;
  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/mux_nto1_serializer_if.sv
// Output word stream of the channel serializer (valid/ready).
interface mux_nto1_serializer_if
  import mux_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SEL_WIDTH  = $clog2(NUM_CH_DEF)
) ();

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [SEL_WIDTH-1:0]  out_ch;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_ch,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_ch,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/mux_nto1_next_ch.sv
// Priority finder: lowest set mask bit above ptr, or from bit 0 when start=1.
module mux_nto1_next_ch
  import mux_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int SEL_WIDTH = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]    mask,
  input  logic [SEL_WIDTH-1:0] ptr,
  input  logic                 start,
  output logic [SEL_WIDTH-1:0] nxt,
  output logic                 none
);

  // Scan downward so the lowest qualifying index wins.
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (start || i > int'(ptr))) begin
        nxt  = SEL_WIDTH'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_serializer.sv
// Captures NUM_CH words on load and drains the enabled ones in ascending order.
module mux_nto1_serializer
  import mux_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SEL_WIDTH  = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]            ch_mask,
  output logic                         busy,
  output logic                         done,
  mux_nto1_serializer_if.master        out_if
);

  state_t                state;
  state_t                state_nx;
  logic [NUM_CH-1:0]     smask;
  logic [DATA_WIDTH-1:0] bank [NUM_CH];
  logic [SEL_WIDTH-1:0]  ptr;
  logic [SEL_WIDTH-1:0]  nxt;
  logic [SEL_WIDTH-1:0]  first;
  logic                  none;
  logic                  none_first;
  logic                  drain;
  logic                  xfer;
  logic                  accept;
  logic                  empty_ld;
  logic                  fin;

  mux_nto1_next_ch #(
    .NUM_CH    (NUM_CH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_step (
    .mask  (smask),
    .ptr   (ptr),
    .start (1'b0),
    .nxt   (nxt),
    .none  (none)
  );

  mux_nto1_next_ch #(
    .NUM_CH    (NUM_CH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_first (
    .mask  (ch_mask),
    .ptr   ('0),
    .start (1'b1),
    .nxt   (first),
    .none  (none_first)
  );

  assign drain = (state == DRAIN);
  assign xfer  = drain & out_if.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    empty_ld = 1'b0;
    fin      = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          if (none_first) begin
            empty_ld = 1'b1;
          end else begin
            accept   = 1'b1;
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (xfer && none) begin
          fin      = 1'b1;
          state_nx = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      smask <= '0;
      done  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) bank[k] <= '0;
    end else begin
      done <= empty_ld | fin;
      if (accept) begin
        smask <= ch_mask;
        ptr   <= first;
        for (int k = 0; k < NUM_CH; k++)
          bank[k] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
      end else if (xfer && !none) begin
        ptr <= nxt;
      end
    end
  end

  // Outputs read only registered state; idle forces them to zero.
  assign busy             = drain;
  assign out_if.out_valid = drain;
  assign out_if.out_data  = drain ? bank[ptr] : '0;
  assign out_if.out_ch    = drain ? ptr : '0;
  assign out_if.out_last  = drain & none;

endmodule

// File: tb/tb_mux_nto1_serializer.sv
// Bench for mux_nto1_serializer: 16x16 and 5x8 instances vs a queue model.
module tb_mux_nto1_serializer;

  typedef struct {
    int ch;
    int data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld  = 1'b0;
  logic        rdy = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] msk = '0;
  int          dat [16];

  logic [255:0] din16;
  logic [39:0]  din5;
  logic         busy16, done16, busy5, done5;

  ent_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  mux_nto1_serializer_if #(.DATA_WIDTH(16), .SEL_WIDTH(4)) if16 ();
  mux_nto1_serializer_if #(.DATA_WIDTH(8),  .SEL_WIDTH(3)) if5 ();

  mux_nto1_serializer #(
    .NUM_CH     (16),
    .DATA_WIDTH (16)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .load    (ld && !sel),
    .data_in (din16),
    .ch_mask (msk),
    .busy    (busy16),
    .done    (done16),
    .out_if  (if16.master)
  );

  mux_nto1_serializer #(
    .NUM_CH     (5),
    .DATA_WIDTH (8)
  ) u_dut5 (
    .clk     (clk),
    .rst     (rst),
    .load    (ld && sel),
    .data_in (din5),
    .ch_mask (msk[4:0]),
    .busy    (busy5),
    .done    (done5),
    .out_if  (if5.master)
  );

  assign if16.out_ready = rdy && !sel;
  assign if5.out_ready  = rdy && sel;

  always #5 clk = ~clk;

  always_comb begin
    din16 = '0;
    din5  = '0;
    for (int k = 0; k < 16; k++) din16[k*16 +: 16] = dat[k][15:0];
    for (int k = 0; k < 5; k++)  din5[k*8 +: 8]    = dat[k][7:0];
  end

  function automatic int sx(int v, int w);
    return (v <<< (32 - w)) >>> (32 - w);
  endfunction

  task automatic check(string tag, int obs, int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: an accepted load becomes a list of (channel, word) to emit.
  task automatic tick();
    int          nch = sel ? 5 : 16;
    int          dw  = sel ? 8 : 16;
    logic [15:0] me  = msk & (sel ? 16'h001F : 16'hFFFF);
    bit          nd  = 0;
    int          o_busy, o_valid, o_done, o_ch, o_data, o_last;
    if (rst) begin
      q.delete();
    end else if (q.size() == 0) begin
      if (ld) begin
        if (me == 0) nd = 1;
        else
          for (int k = 0; k < nch; k++)
            if (me[k]) q.push_back('{k, sx(dat[k], dw)});
      end
    end else if (rdy) begin
      void'(q.pop_front());
      if (q.size() == 0) nd = 1;
    end
    @(posedge clk);
    #1;
    o_busy  = sel ? int'(busy5) : int'(busy16);
    o_done  = sel ? int'(done5) : int'(done16);
    o_valid = sel ? int'(if5.out_valid) : int'(if16.out_valid);
    o_ch    = sel ? int'(if5.out_ch) : int'(if16.out_ch);
    o_data  = sel ? int'($signed(if5.out_data)) : int'($signed(if16.out_data));
    o_last  = sel ? int'(if5.out_last) : int'(if16.out_last);
    check("busy", o_busy, int'(q.size() != 0));
    check("out_valid", o_valid, int'(q.size() != 0));
    check("done", o_done, int'(nd));
    if (q.size() != 0) begin
      check("out_ch", o_ch, q[0].ch);
      check("out_data", o_data, q[0].data);
      check("out_last", o_last, int'(q.size() == 1));
    end else if (rst) begin
      check("rst_out_ch", o_ch, 0);
      check("rst_out_data", o_data, 0);
      check("rst_out_last", o_last, 0);
    end
  endtask

  task automatic settle();
    ld  = 1'b0;
    rdy = 1'b1;
    rst = 1'b0;
    repeat (20) tick();
  endtask

  initial begin
    for (int k = 0; k < 16; k++) dat[k] = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // full drain, data k*3-20
    for (int k = 0; k < 16; k++) dat[k] = k * 3 - 20;
    msk = 16'hFFFF; ld = 1'b1; rdy = 1'b1;
    tick();
    ld = 1'b0;
    repeat (18) tick();

    // sparse mask
    msk = 16'h8421; ld = 1'b1;
    tick();
    ld = 1'b0;
    repeat (6) tick();

    // backpressure on first word
    for (int k = 0; k < 16; k++) dat[k] = $urandom;
    msk = 16'h0006; ld = 1'b1; rdy = 1'b0;
    tick();
    ld = 1'b0;
    repeat (3) tick();
    rdy = 1'b1;
    repeat (4) tick();

    // empty load
    msk = 16'h0000; ld = 1'b1;
    tick();
    ld = 1'b0;
    repeat (2) tick();

    // load during drain is ignored, new data has no effect
    for (int k = 0; k < 16; k++) dat[k] = $urandom;
    msk = 16'hFFFF; ld = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < 16; k++) dat[k] = $urandom;
      msk = 16'($urandom);
      tick();
    end
    ld = 1'b0;
    repeat (18) tick();

    // reset during the third transfer, then fresh drain
    for (int k = 0; k < 16; k++) dat[k] = k * 3 - 20;
    msk = 16'hFFFF; ld = 1'b1;
    tick();
    ld = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ld = 1'b1;
    tick();
    ld = 1'b0;
    repeat (18) tick();

    // random traffic on the 16-channel instance
    for (int i = 0; i < 300; i++) begin
      ld  = ($urandom_range(0, 3) == 0);
      msk = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 1) == 1)
        for (int k = 0; k < 16; k++) dat[k] = $urandom;
      tick();
    end
    settle();

    // 5-channel, 8-bit instance: single top channel with 0x80
    sel = 1'b1;
    settle();
    for (int k = 0; k < 16; k++) dat[k] = 0;
    dat[4] = 32'h80;
    msk = 16'h0010; ld = 1'b1;
    tick();
    ld = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 200; i++) begin
      ld  = ($urandom_range(0, 2) == 0);
      msk = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) == 0);
      for (int k = 0; k < 16; k++) dat[k] = $urandom;
      tick();
    end
    settle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_nto1_serializer.md
Name: mux_nto1_serializer

Overview:
- Parametrised successor to the fixed 16-to-1 combinational mux.
- Captures NUM_CH channel words (e.g. one PE row of the transpose-convolution array) into a shadow bank on a load strobe.
- Drains the captured words one per accepted transfer, in ascending channel order, over a valid/ready stream.
- Skips channels disabled by a per-load mask and signals completion. Sits between the PE output bank and the output-memory write path.

Parameters:
- NUM_CH, 16, number of input channels (≥2).
- DATA_WIDTH, 16, signed word width per channel.
- SEL_WIDTH, $clog2(NUM_CH), width of the channel index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture strobe; accepted only when busy=0.
- data_in  in  NUM_CH*DATA_WIDTH  flattened channels; channel k = data_in[k*DATA_WIDTH +: DATA_WIDTH].
- ch_mask  in  NUM_CH  1 = channel k is emitted; captured with data_in.
- busy  out  1  high from the cycle after an accepted load until the final handshake.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  signed word of the current channel.
- out_ch  out  SEL_WIDTH  index of the current channel.
- out_last  out  1  high with out_valid on the last enabled channel.
- done  out  1  one-cycle pulse after a drain completes.

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous and active-high.
- Reset values: busy=0, out_valid=0, out_data=0, out_ch=0, out_last=0, done=0; shadow bank, shadow mask and pointer cleared; state IDLE.
- States: IDLE, DRAIN.
- IDLE, load=1 and ch_mask≠0:
  - capture data_in and ch_mask;
  - ptr ← lowest set bit of ch_mask;
  - next cycle: state DRAIN, busy=1, out_valid=1.
  - Latency load→first out_valid = 1 cycle.
- IDLE, load=1 and ch_mask=0: nothing captured; done=1 in the next cycle; stay IDLE; out_valid never asserts.
- DRAIN:
  - out_data = shadow[ptr] and out_ch = ptr, driven from registers only.
  - out_last = 1 when no mask bit above ptr is set.
- Handshake: a transfer occurs when out_valid & out_ready.
  - On a transfer with out_last=0: ptr ← next set mask bit above ptr; no bubble cycle.
  - On a transfer with out_last=1: next cycle IDLE, busy=0, out_valid=0, done=1 for exactly one cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_ch and out_last hold stable. out_valid never drops without a transfer.
- load while busy=1 is ignored; the shadow bank is untouched. This includes load in the same cycle as the final transfer.
- load in the done cycle (state IDLE) is accepted normally.
- Changes to data_in or ch_mask after capture have no effect on the current drain.
- Reset mid-drain: immediate abort, reset values next cycle, no done pulse.
- Arithmetic: no arithmetic on data. Words pass bit-exact, sign preserved. ptr never exceeds NUM_CH-1.

Decomposition:
- Shared package mux_pkg holds the default NUM_CH / DATA_WIDTH constants and the state encoding (IDLE=1'b0, DRAIN=1'b1).
- One sub-module, mux_nto1_next_ch: a combinational priority finder. Inputs: mask and ptr. Outputs: next set index above ptr, plus a "none" flag that drives out_last. It is also reused for the initial lowest-set-bit search with ptr treated as -1.

Test Plan:
- Full drain: mask=16'hFFFF, data k=k*3-20, out_ready=1 → 16 consecutive transfers, out_ch 0..15, out_data -20..25, out_last on ch15, done pulse in the following cycle.
- Sparse mask: mask=16'h8421 → exactly 4 transfers on ch 0,5,10,15; out_last on ch15; busy high 4 cycles.
- Backpressure: mask=16'h0006, out_ready low 3 cycles on the first word → out_data/out_ch (ch1) held stable; then ch2 with out_last; then done.
- Empty and ignored loads: mask=0 → done one cycle later, out_valid stays 0. A load with new data issued mid-drain → the original words are emitted unchanged.
- Reset abort: rst asserted during the 3rd transfer of a full drain → all outputs 0 next cycle, no done. A fresh load afterwards drains correctly from ch0.
- Parametrisation: NUM_CH=5, DATA_WIDTH=8, mask=5'b10000, data4=8'h80 → single transfer, out_ch=4, out_data=-128, out_last=1.
